pitch_tone_synth: RTL and testbench

PITCH_TONE_SYNTH -- requirements
Module: pitch_tone_synth

---
 rtl/pitch_synth_pkg.sv | 27 ++
 rtl/tone_wave_gen.sv | 49 ++++
 rtl/pitch_tone_synth.sv | 211 +++++++++++++++++++++
 tb/tb_pitch_tone_synth.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pitch_synth_pkg.sv
// -----------------------------------------------------------------------------
// pitch_synth_pkg
// Shared types and constants for the pitch-following tone synthesizer.
//   synth_state_t : envelope FSM states (IDLE, ATTACK, SUSTAIN, RELEASE)
//   PHASE_W       : phase accumulator / increment width
//   GAIN_W        : envelope gain width (unsigned, 0..GAIN_MAX)
//   GAIN_MAX      : full-scale gain (unity after the GAIN_FRAC shift)
//   GAIN_FRAC     : fractional bits of the gain (sample = tri * gain >>> 8)
//   INC_SHIFT     : left shift turning an FFT bin index into a phase increment
// -----------------------------------------------------------------------------
package pitch_synth_pkg;

    localparam int PHASE_W   = 32;
    localparam int GAIN_W    = 9;
    localparam int GAIN_FRAC = 8;
    localparam int INC_SHIFT = 20;

    localparam logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(256);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } synth_state_t;

endpackage

// File: rtl/tone_wave_gen.sv
// -----------------------------------------------------------------------------
// tone_wave_gen
// Phase accumulator plus triangle mapping. The triangle is computed from the
// phase value that will be stored at this advance, so the caller can register
// the resulting sample in the same cycle as the phase update.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (clears phase)
//   i_adv      : advance enable (one sample step)
//   i_clr      : next phase is zero instead of phase + i_inc
//   i_inc      : phase increment (modulo 2^PHASE_W)
//   o_tri      : signed W-bit triangle of the next phase
// -----------------------------------------------------------------------------
module tone_wave_gen
    import pitch_synth_pkg::*;
#(
    parameter int W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_adv,
    input  logic               i_clr,
    input  logic [PHASE_W-1:0] i_inc,
    output logic [W-1:0]       o_tri
);

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_next;
    logic [W-1:0]       w_p;
    logic [W-2:0]       w_u;

    assign w_phase_next = i_clr ? '0 : r_phase + i_inc;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (i_adv) begin
            r_phase <= w_phase_next;
        end
    end

    // Upper W phase bits; the second half-period is mirrored so the ramp folds
    // into a triangle. Subtracting 2^(W-1) recentres it around zero.
    assign w_p   = w_phase_next[PHASE_W-1 -: W];
    assign w_u   = w_p[W-1] ? ~w_p[W-2:0] : w_p[W-2:0];
    assign o_tri = {w_u, 1'b0} - {1'b1, {(W-1){1'b0}}};

endmodule

// File: rtl/pitch_tone_synth.sv
// -----------------------------------------------------------------------------
// pitch_tone_synth
// Turns FFT pitch estimates into a triangle tone with an attack / sustain /
// release envelope, streamed out one sample per downstream handshake.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   pitch_k      : FFT bin index from the pitch detector (0 = no pitch)
//   pitch_valid  : pitch_k qualifier, always accepted
//   mute         : forces release and discards new notes while high
//   y_data       : signed output sample
//   y_valid      : sample valid (high from the first cycle after reset)
//   y_ready      : downstream sample-rate strobe
//   note_on      : envelope is not IDLE
// Everything (phase, gain, state, hold counter, y_data) advances only on a
// handshake; pitch updates are buffered and applied at the next handshake.
// -----------------------------------------------------------------------------
module pitch_tone_synth
    import pitch_synth_pkg::*;
#(
    parameter int W            = 16,
    parameter int NSamples     = 1024,
    parameter int HOLD_SAMPLES = 4800,
    parameter int STEP         = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(NSamples)-1:0] pitch_k,
    input  logic                        pitch_valid,
    input  logic                        mute,
    output logic [W-1:0]                y_data,
    output logic                        y_valid,
    input  logic                        y_ready,
    output logic                        note_on
);

    localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
    localparam int PROD_W = W + GAIN_W + 1;

    localparam logic [GAIN_W-1:0] STEP_G    = GAIN_W'(STEP);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SAMPLES);

    synth_state_t r_state;
    synth_state_t w_state_next;
    synth_state_t w_rise_state;

    logic [PHASE_W-1:0] r_inc_pend;
    logic [PHASE_W-1:0] r_inc_act;
    logic [PHASE_W-1:0] w_inc_eff;
    logic               r_event_pend;

    logic [GAIN_W-1:0]  r_gain;
    logic [GAIN_W-1:0]  w_gain_next;
    logic [GAIN_W:0]    w_gain_up;
    logic [GAIN_W-1:0]  w_gain_rise;
    logic [GAIN_W-1:0]  w_gain_fall;

    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  w_hold_next;
    logic [HOLD_W-1:0]  w_hold_inc;

    logic [W-1:0]       r_y_data;
    logic               r_y_valid;
    logic [W-1:0]       w_tri;
    logic [W-1:0]       w_sample;

    logic signed [PROD_W-1:0] w_tri_ext;
    logic signed [PROD_W-1:0] w_gain_ext;
    logic signed [PROD_W-1:0] w_prod;

    logic w_hs;
    logic w_capture;
    logic w_ev_apply;
    logic w_phase_clr;

    assign w_hs      = r_y_valid && y_ready;
    assign w_capture = pitch_valid && (pitch_k != '0);

    // A pending note is applied only when mute is low; under mute it is
    // dropped at the handshake instead.
    assign w_ev_apply = r_event_pend && !mute;
    assign w_inc_eff  = w_ev_apply ? r_inc_pend : r_inc_act;

    // Envelope step candidates.
    assign w_gain_up    = {1'b0, r_gain} + {1'b0, STEP_G};
    assign w_gain_rise  = (w_gain_up >= {1'b0, GAIN_MAX}) ? GAIN_MAX : w_gain_up[GAIN_W-1:0];
    assign w_gain_fall  = (r_gain <= STEP_G) ? '0 : r_gain - STEP_G;
    assign w_rise_state = (w_gain_rise == GAIN_MAX) ? SUSTAIN : ATTACK;
    assign w_hold_inc   = r_hold + HOLD_W'(1);

    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned (which would infer a latch).
    always_comb begin
        w_state_next = r_state;
        w_gain_next  = r_gain;
        w_hold_next  = r_hold;
        w_phase_clr  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_ev_apply) begin
                    w_gain_next  = w_gain_rise;
                    w_state_next = w_rise_state;
                    w_hold_next  = '0;
                end else begin
                    w_gain_next = '0;
                    w_phase_clr = 1'b1;
                end
            end
            ATTACK: begin
                if (mute) begin
                    w_state_next = RELEASE;
                end else begin
                    w_gain_next  = w_gain_rise;
                    w_state_next = w_rise_state;
                    w_hold_next  = '0;
                end
            end
            SUSTAIN: begin
                if (mute) begin
                    w_state_next = RELEASE;
                    w_hold_next  = '0;
                end else if (w_ev_apply) begin
                    // Fresh pitch restarts the hold window.
                    w_hold_next = '0;
                end else if (w_hold_inc == HOLD_LAST) begin
                    w_state_next = RELEASE;
                    w_hold_next  = '0;
                end else begin
                    w_hold_next = w_hold_inc;
                end
            end
            RELEASE: begin
                if (w_ev_apply) begin
                    // Retrigger ramps up from wherever the release had reached.
                    w_gain_next  = w_gain_rise;
                    w_state_next = w_rise_state;
                    w_hold_next  = '0;
                end else begin
                    w_gain_next = w_gain_fall;
                    if (w_gain_fall == '0) begin
                        w_state_next = IDLE;
                        w_phase_clr  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_gain  <= '0;
            r_hold  <= '0;
        end else if (w_hs) begin
            r_state <= w_state_next;
            r_gain  <= w_gain_next;
            r_hold  <= w_hold_next;
        end
    end

    tone_wave_gen #(
        .W (W)
    ) u_wave (
        .clk   (clk),
        .reset (reset),
        .i_adv (w_hs),
        .i_clr (w_phase_clr),
        .i_inc (w_inc_eff),
        .o_tri (w_tri)
    );

    // Sample = triangle scaled by the gain being stored this handshake.
    assign w_tri_ext  = PROD_W'($signed(w_tri));
    assign w_gain_ext = PROD_W'($signed({1'b0, w_gain_next}));
    assign w_prod     = w_tri_ext * w_gain_ext;
    assign w_sample   = W'(w_prod >>> GAIN_FRAC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inc_pend   <= '0;
            r_inc_act    <= '0;
            r_event_pend <= 1'b0;
            r_y_data     <= '0;
            r_y_valid    <= 1'b0;
        end else begin
            r_y_valid <= 1'b1;
            if (w_capture) begin
                r_inc_pend <= PHASE_W'(pitch_k) << INC_SHIFT;
            end
            // A capture in the handshake cycle wins, so it waits for the next one.
            if (w_capture) begin
                r_event_pend <= 1'b1;
            end else if (w_hs) begin
                r_event_pend <= 1'b0;
            end
            if (w_hs) begin
                r_y_data <= w_sample;
                if (w_ev_apply) begin
                    r_inc_act <= r_inc_pend;
                end
            end
        end
    end

    assign y_data  = r_y_data;
    assign y_valid = r_y_valid;
    assign note_on = (r_state != IDLE);

endmodule

// File: tb/tb_pitch_tone_synth.sv
// -----------------------------------------------------------------------------
// tb_pitch_tone_synth
// Self-checking bench: directed scenarios plus randomized pitch / mute /
// back-pressure traffic, compared every cycle against an integer model of the
// synthesizer's sample stream.
// -----------------------------------------------------------------------------
module tb_pitch_tone_synth;

    localparam int W        = 16;
    localparam int NSAMPLES = 1024;
    localparam int HOLD     = 4800;
    localparam int STEP     = 1;
    localparam int KW       = $clog2(NSAMPLES);

    localparam int M_IDLE    = 0;
    localparam int M_ATTACK  = 1;
    localparam int M_SUSTAIN = 2;
    localparam int M_RELEASE = 3;

    logic          clk         = 1'b0;
    logic          reset       = 1'b1;
    logic [KW-1:0] pitch_k     = '0;
    logic          pitch_valid = 1'b0;
    logic          mute        = 1'b0;
    logic          y_ready     = 1'b1;
    logic [W-1:0]  y_data;
    logic          y_valid;
    logic          note_on;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int        m_mode;
    int        m_gain;
    int        m_hold;
    bit [31:0] m_phase;
    bit [31:0] m_inc;
    bit [31:0] m_inc_pend;
    bit        m_pend;
    bit        m_y_valid;
    longint    m_y;

    pitch_tone_synth #(
        .W            (W),
        .NSamples     (NSAMPLES),
        .HOLD_SAMPLES (HOLD),
        .STEP         (STEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pitch_k     (pitch_k),
        .pitch_valid (pitch_valid),
        .mute        (mute),
        .y_data      (y_data),
        .y_valid     (y_valid),
        .y_ready     (y_ready),
        .note_on     (note_on)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Triangle from the top W phase bits: rising ramp over the first half
    // period, falling ramp over the second, centred on zero.
    function automatic longint tri_sample(bit [31:0] ph, int g);
        longint p;
        longint t;
        p = longint'(ph >> (32 - W));
        if (p < 2**(W-1)) t = 2 * p - 2**(W-1);
        else              t = 2 * (2**W - 1 - p) - 2**(W-1);
        return (t * g) >>> 8;
    endfunction

    task automatic model_reset();
        m_mode     = M_IDLE;
        m_gain     = 0;
        m_hold     = 0;
        m_phase    = '0;
        m_inc      = '0;
        m_inc_pend = '0;
        m_pend     = 1'b0;
        m_y_valid  = 1'b0;
        m_y        = 0;
    endtask

    // Predict the effect of the coming clock edge from the current inputs.
    task automatic model_edge();
        bit hs;
        bit fresh;
        hs = m_y_valid && y_ready;
        if (hs) begin
            fresh = m_pend && !mute;
            if (fresh) m_inc = m_inc_pend;
            m_pend = 1'b0;
            if (mute && (m_mode == M_ATTACK || m_mode == M_SUSTAIN)) begin
                m_mode = M_RELEASE;
                m_hold = 0;
            end else if (fresh && m_mode == M_SUSTAIN) begin
                m_hold = 0;
            end else if (fresh || m_mode == M_ATTACK) begin
                m_gain = (m_gain + STEP > 256) ? 256 : m_gain + STEP;
                m_mode = (m_gain == 256) ? M_SUSTAIN : M_ATTACK;
                m_hold = 0;
            end else if (m_mode == M_SUSTAIN) begin
                m_hold++;
                if (m_hold == HOLD) begin
                    m_mode = M_RELEASE;
                    m_hold = 0;
                end
            end else if (m_mode == M_RELEASE) begin
                m_gain = (m_gain < STEP) ? 0 : m_gain - STEP;
                if (m_gain == 0) m_mode = M_IDLE;
            end
            m_phase = (m_mode == M_IDLE) ? 32'd0 : m_phase + m_inc;
            m_y     = tri_sample(m_phase, m_gain);
        end
        if (pitch_valid && pitch_k != '0) begin
            m_inc_pend = 32'(pitch_k) << 20;
            m_pend     = 1'b1;
        end
        m_y_valid = 1'b1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("y_valid", longint'(y_valid), longint'(m_y_valid));
        check("y_data", longint'($signed(y_data)), m_y);
        check("note_on", longint'(note_on), longint'(m_mode != M_IDLE));
    endtask

    task automatic pulse(input int k);
        pitch_k     = KW'(k);
        pitch_valid = 1'b1;
        tick();
        pitch_valid = 1'b0;
    endtask

    initial begin
        int k1;
        int k2;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_y_valid", longint'(y_valid), 0);
        check("rst_y_data", longint'($signed(y_data)), 0);
        check("rst_note_on", longint'(note_on), 0);
        reset = 1'b0;

        // Idle stream: valid from the first edge, silent
        repeat (5) tick();
        check("idle_y_valid", longint'(y_valid), 1);
        check("idle_y_data", longint'($signed(y_data)), 0);
        check("idle_note_on", longint'(note_on), 0);

        // Bin 16: first sample at phase 0x0100_0000 with gain 1
        pulse(16);
        tick();
        check("first_note_sample", longint'($signed(y_data)), -126);
        check("note_on_attack", longint'(note_on), 1);

        // 255 more attack steps, 4800 sustain, 255 of 256 release steps
        repeat (255) tick();
        repeat (HOLD + 255) tick();
        check("release_last_note_on", longint'(note_on), 1);
        tick();
        check("release_end_note_on", longint'(note_on), 0);
        check("release_end_y_data", longint'($signed(y_data)), 0);

        // Back-pressure mid-attack with a pitch change during the stall
        k1 = $urandom_range(1, NSAMPLES - 1);
        k2 = (k1 % (NSAMPLES - 1)) + 1;
        pulse(k1);
        repeat (40) tick();
        y_ready = 1'b0;
        repeat (4) tick();
        pulse(k2);
        repeat (5) tick();
        check("stall_y_valid", longint'(y_valid), 1);
        y_ready = 1'b1;
        repeat (21) tick();

        // Mute in sustain with a coincident pitch pulse
        repeat (300) tick();
        check("sustain_note_on", longint'(note_on), 1);
        mute = 1'b1;
        pulse(32);
        repeat (300) tick();
        check("mute_note_on", longint'(note_on), 0);
        mute = 1'b0;
        repeat (20) tick();
        check("mute_pulse_ignored", longint'(note_on), 0);
        check("mute_y_data", longint'($signed(y_data)), 0);

        // Partial release followed by a retrigger
        pulse(64);
        repeat (100) tick();
        mute = 1'b1;
        repeat (30) tick();
        mute = 1'b0;
        pulse(100);
        repeat (40) tick();
        check("retrigger_note_on", longint'(note_on), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            y_ready = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 149) == 0) mute = ~mute;
            pitch_valid = ($urandom_range(0, 39) == 0);
            pitch_k     = ($urandom_range(0, 3) == 0) ? '0 : KW'($urandom_range(1, NSAMPLES - 1));
            tick();
        end
        pitch_valid = 1'b0;
        y_ready     = 1'b1;
        mute        = 1'b1;
        repeat (300) tick();
        mute = 1'b0;

        // Asynchronous reset in the middle of an attack (gain 100)
        pulse(200);
        for (int i = 0; i < 400 && m_gain != 100; i++) tick();
        #3;
        reset = 1'b1;
        #1;
        check("arst_y_data", longint'($signed(y_data)), 0);
        check("arst_y_valid", longint'(y_valid), 0);
        check("arst_note_on", longint'(note_on), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) tick();
        check("post_rst_y_data", longint'($signed(y_data)), 0);
        check("post_rst_note_on", longint'(note_on), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
